// File: rtl/addpfx_pkg.sv
// Shared types and helpers for the time-shared prefix-adder scheduler.
package addpfx_pkg;

   localparam int LIMB_W   = 8;
   localparam int MAX_REQ  = 8;
   localparam int ID_MAX_W = 3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic [LIMB_W-1:0]   sum;
      logic                cout;
      logic [ID_MAX_W-1:0] id;
      logic                last;
      logic                err;
   } result_t;

   // Returns {found, index}: first set valid bit at or after ptr, wrapping at nreq.
   function automatic logic [ID_MAX_W:0] rr_pick(
      input logic [MAX_REQ-1:0]  valid,
      input logic [ID_MAX_W-1:0] ptr,
      input int unsigned         nreq
   );
      logic [ID_MAX_W:0] res;
      int unsigned       idx;
      res = {(ID_MAX_W+1){1'b0}};
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= nreq) begin
            idx = idx - nreq;
         end
         if ((k < nreq) && !res[ID_MAX_W] && valid[idx[ID_MAX_W-1:0]]) begin
            res = {1'b1, idx[ID_MAX_W-1:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/addpfx_core_ci.sv
// Combinational 8-bit Sklansky prefix adder; carry-in enters as an extra
// generate-only position below bit 0.
module addpfx_core_ci
   import addpfx_pkg::*;
(
   input  logic [LIMB_W-1:0] i_a,
   input  logic [LIMB_W-1:0] i_b,
   input  logic              i_cin,
   output logic [LIMB_W-1:0] o_sum,
   output logic              o_cout
);

   localparam int N   = LIMB_W + 1;
   localparam int LVL = $clog2(N);

   wire [N-1:0] w_g [0:LVL];
   wire [N-1:0] w_p [0:LVL];

   assign w_g[0] = {i_a & i_b, i_cin};
   assign w_p[0] = {i_a ^ i_b, 1'b0};

   genvar l, i;
   generate
      for (l = 0; l < LVL; l++) begin : g_lvl
         for (i = 0; i < N; i++) begin : g_bit
            if (((i >> l) & 1) == 1) begin : g_comb
               localparam int J = ((i >> l) << l) - 1;
               assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][J]);
               assign w_p[l+1][i] = w_p[l][i] & w_p[l][J];
            end else begin : g_pass
               assign w_g[l+1][i] = w_g[l][i];
               assign w_p[l+1][i] = w_p[l][i];
            end
         end
      end
   endgenerate

   // Position k of the final generate vector is the carry into bit k.
   assign o_sum  = w_p[0][N-1:1] ^ w_g[LVL][N-2:0];
   assign o_cout = w_g[LVL][N-1];

endmodule

// File: rtl/addpfx_sched.sv
// Arbitrates NREQ multi-limb add streams onto one prefix adder, chaining
// carry per transaction and returning one registered result per beat.
module addpfx_sched
   import addpfx_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int MAXBEATS = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NREQ-1:0]          i_req_valid,
   output logic [NREQ-1:0]          o_req_ready,
   input  logic [LIMB_W*NREQ-1:0]   i_req_a,
   input  logic [LIMB_W*NREQ-1:0]   i_req_b,
   input  logic [NREQ-1:0]          i_req_last,
   output logic                     o_res_valid,
   input  logic                     i_res_ready,
   output logic [LIMB_W-1:0]        o_res_sum,
   output logic                     o_res_cout,
   output logic [$clog2(NREQ)-1:0]  o_res_id,
   output logic                     o_res_last,
   output logic                     o_res_err
);

   localparam int IDW  = $clog2(NREQ);
   localparam int CNTW = $clog2(MAXBEATS + 1);

   state_e            r_state;
   logic [IDW-1:0]    r_owner;
   logic [IDW-1:0]    r_rr_ptr;
   logic              r_carry;
   logic [CNTW-1:0]   r_beat_cnt;
   logic              r_res_valid;
   result_t           r_res;

   logic              w_out_free;
   logic [MAX_REQ-1:0] w_valid8;
   logic [ID_MAX_W-1:0] w_ptr3;
   logic [ID_MAX_W:0] w_pick;
   logic              w_grant_ok;
   logic [IDW-1:0]    w_grant_idx;
   logic [ID_MAX_W-1:0] w_grant_id3;
   logic              w_cin;
   logic [NREQ-1:0]   w_ready;
   logic              w_accept;
   logic              w_last;
   logic              w_trunc;
   logic              w_end;
   logic [LIMB_W-1:0] w_a;
   logic [LIMB_W-1:0] w_b;
   logic [LIMB_W-1:0] w_sum;
   logic              w_cout;
   logic [IDW-1:0]    w_next_ptr;
   result_t           w_res;

   assign w_out_free = !r_res_valid || i_res_ready;

   // Widen request vector and pointer to the fixed arbiter width.
   always_comb begin
      w_valid8              = {MAX_REQ{1'b0}};
      w_valid8[NREQ-1:0]    = i_req_valid;
      w_ptr3                = {ID_MAX_W{1'b0}};
      w_ptr3[IDW-1:0]       = r_rr_ptr;
      w_grant_id3           = {ID_MAX_W{1'b0}};
      w_grant_id3[IDW-1:0]  = w_grant_idx;
   end

   assign w_pick = rr_pick(w_valid8, w_ptr3, NREQ);

   // Grant selection: round-robin when idle, locked owner when busy.
   always_comb begin
      case (r_state)
         ST_IDLE: begin
            w_grant_ok  = w_pick[ID_MAX_W];
            w_grant_idx = w_pick[IDW-1:0];
            w_cin       = 1'b0;
         end
         ST_BUSY: begin
            w_grant_ok  = 1'b1;
            w_grant_idx = r_owner;
            w_cin       = r_carry;
         end
         default: begin
            w_grant_ok  = 1'b0;
            w_grant_idx = {IDW{1'b0}};
            w_cin       = 1'b0;
         end
      endcase
   end

   // One-hot ready to the granted requester only.
   always_comb begin
      w_ready = {NREQ{1'b0}};
      if (!i_rst && w_grant_ok && w_out_free) begin
         w_ready[w_grant_idx] = 1'b1;
      end else begin
         w_ready = {NREQ{1'b0}};
      end
   end

   assign o_req_ready = w_ready;
   assign w_accept    = w_ready[w_grant_idx] & i_req_valid[w_grant_idx];
   assign w_last      = i_req_last[w_grant_idx];
   assign w_a         = i_req_a[w_grant_idx*LIMB_W +: LIMB_W];
   assign w_b         = i_req_b[w_grant_idx*LIMB_W +: LIMB_W];
   assign w_trunc     = !w_last && (r_beat_cnt == CNTW'(MAXBEATS - 1));
   assign w_end       = w_last || w_trunc;
   assign w_next_ptr  = (w_grant_idx == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (w_grant_idx + IDW'(1));

   addpfx_core_ci u_core (
      .i_a    (w_a),
      .i_b    (w_b),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Assemble the result beat presented to the output register.
   always_comb begin
      w_res.sum  = w_sum;
      w_res.cout = w_cout;
      w_res.id   = w_grant_id3;
      w_res.last = w_end;
      w_res.err  = w_trunc;
   end

   // Scheduler FSM, carry chain and output register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= {IDW{1'b0}};
         r_rr_ptr    <= {IDW{1'b0}};
         r_carry     <= 1'b0;
         r_beat_cnt  <= {CNTW{1'b0}};
         r_res_valid <= 1'b0;
         r_res       <= '{sum: 8'd0, cout: 1'b0, id: 3'd0, last: 1'b0, err: 1'b0};
      end else begin
         if (w_out_free) begin
            r_res_valid <= w_accept;
            if (w_accept) begin
               r_res <= w_res;
            end
         end
         if (w_accept) begin
            r_carry <= w_cout;
            if (w_end) begin
               r_state    <= ST_IDLE;
               r_beat_cnt <= {CNTW{1'b0}};
               r_rr_ptr   <= w_next_ptr;
            end else begin
               r_state    <= ST_BUSY;
               r_owner    <= w_grant_idx;
               r_beat_cnt <= r_beat_cnt + CNTW'(1);
            end
         end
      end
   end

   assign o_res_valid = r_res_valid;
   assign o_res_sum   = r_res.sum;
   assign o_res_cout  = r_res.cout;
   assign o_res_id    = r_res.id[IDW-1:0];
   assign o_res_last  = r_res.last;
   assign o_res_err   = r_res.err;

endmodule

// File: tb/tb_addpfx_sched.sv
// Self-checking bench for addpfx_sched: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_addpfx_sched;

   localparam int NREQ = 4;
   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = 4'h0;
   logic [3:0]  req_last  = 4'h0;
   logic [31:0] req_a = 32'h0;
   logic [31:0] req_b = 32'h0;
   logic        res_ready = 1'b1;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic [7:0]  res_sum;
   logic        res_cout;
   logic [1:0]  res_id;
   logic        res_last;
   logic        res_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // model state
   bit         m_valid = 1'b0;
   logic [7:0] m_sum   = 8'h0;
   bit         m_cout  = 1'b0;
   logic [1:0] m_id    = 2'd0;
   bit         m_last  = 1'b0;
   bit         m_err   = 1'b0;
   int         m_owner = -1;
   int         m_rr    = 0;
   int         m_carry = 0;
   int         m_beats = 0;

   addpfx_sched #(.NREQ(NREQ), .MAXBEATS(MAXB)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .i_req_last  (req_last),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_sum   (res_sum),
      .o_res_cout  (res_cout),
      .o_res_id    (res_id),
      .o_res_last  (res_last),
      .o_res_err   (res_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_res(input string name, input logic [7:0] s, input logic c,
                          input logic [1:0] id, input logic l, input logic e);
      chk(name, {19'd0, res_valid, res_sum, res_cout, res_id, res_last, res_err},
                {19'd0, 1'b1, s, c, id, l, e});
   endtask

   task automatic set_req(input int r, input logic v, input logic [7:0] a,
                          input logic [7:0] b, input logic l);
      req_valid[r]     = v;
      req_a[r*8 +: 8]  = a;
      req_b[r*8 +: 8]  = b;
      req_last[r]      = l;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req_valid = 4'h0;
      rst = 1'b1;
      step;
      step;
      rst = 1'b0;
   endtask

   // Reference model: evaluated mid-cycle on stable inputs, advanced to the
   // state that must hold after the coming rising edge.
   initial begin : model
      int         g;
      int         idx;
      logic [3:0] er;
      bit         free;
      bit         acc;
      bit         trunc;
      int         cin;
      int         tot;
      logic [17:0] act;
      logic [17:0] exp;
      forever begin
         @(negedge clk);
         free = !m_valid || res_ready;
         er   = 4'h0;
         g    = -1;
         if (!rst) begin
            if (m_owner >= 0) g = m_owner;
            else begin
               for (int k = 0; k < NREQ; k++) begin
                  idx = (m_rr + k) % NREQ;
                  if (g < 0 && req_valid[idx]) g = idx;
               end
            end
            if (g >= 0 && free) er[g] = 1'b1;
         end
         exp = {m_valid, m_valid ? {m_sum, m_cout, m_id, m_last, m_err} : 13'd0, er};
         act = {res_valid, res_valid ? {res_sum, res_cout, res_id, res_last, res_err} : 13'd0, req_ready};
         chk("model_cycle", {14'd0, act}, {14'd0, exp});
         if (rst) begin
            m_valid = 1'b0; m_sum = 8'h0; m_cout = 1'b0; m_id = 2'd0;
            m_last = 1'b0; m_err = 1'b0;
            m_owner = -1; m_rr = 0; m_carry = 0; m_beats = 0;
         end else begin
            acc = (g >= 0) && er[g] && req_valid[g];
            if (free) m_valid = acc;
            if (acc) begin
               cin   = (m_owner >= 0) ? m_carry : 0;
               tot   = int'(req_a[g*8 +: 8]) + int'(req_b[g*8 +: 8]) + cin;
               trunc = !req_last[g] && (m_beats == MAXB - 1);
               m_sum  = tot[7:0];
               m_cout = tot[8];
               m_id   = g[1:0];
               m_last = req_last[g] || trunc;
               m_err  = trunc;
               m_carry = tot >> 8;
               if (m_last) begin
                  m_owner = -1;
                  m_beats = 0;
                  m_rr    = (g + 1) % NREQ;
               end else begin
                  m_owner = g;
                  m_beats = m_beats + 1;
               end
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] t6_sum  [5] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00};
      logic       t6_last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       t6_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      // reset with all requesters valid
      req_valid = 4'hF;
      step;
      chk("reset_ready", {28'd0, req_ready}, 32'd0);
      chk("reset_outputs", {19'd0, res_valid, res_sum, res_cout, res_id, res_last, res_err}, 32'd0);
      step;
      rst = 1'b0;
      req_valid = 4'h0;
      step;

      // single beat on req0
      set_req(0, 1'b1, 8'hFF, 8'h01, 1'b1);
      #1 chk("t1_ready", {28'd0, req_ready}, 32'h1);
      step;
      req_valid = 4'h0;
      chk_res("t1_res", 8'h00, 1'b1, 2'd0, 1'b1, 1'b0);
      step;

      // two-limb chain on req1: 0x00FF + 0x0001 = 0x0100
      set_req(1, 1'b1, 8'hFF, 8'h01, 1'b0);
      step;
      chk_res("t2_lo", 8'h00, 1'b1, 2'd1, 1'b0, 1'b0);
      set_req(1, 1'b1, 8'h00, 8'h00, 1'b1);
      step;
      chk_res("t2_hi", 8'h01, 1'b0, 2'd1, 1'b1, 1'b0);
      req_valid = 4'h0;
      step;

      // round-robin fairness from reset
      do_reset;
      req_a = 32'h0; req_b = 32'h0; req_last = 4'hF; req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         step;
         chk("t3_grant", {30'd0, res_id}, k % 4);
         chk("t3_onehot", $countones(req_ready), 32'd1);
      end
      req_valid = 4'h0;
      step;

      // lock with bubbles, req3 waiting
      do_reset;
      set_req(2, 1'b1, 8'hF0, 8'h20, 1'b0);
      set_req(3, 1'b1, 8'h01, 8'h01, 1'b1);
      step;
      chk_res("t4_b1", 8'h10, 1'b1, 2'd2, 1'b0, 1'b0);
      req_valid[2] = 1'b0;
      #1 chk("t4_lock_ready", {28'd0, req_ready}, 32'h4);
      step;
      chk("t4_gap_valid", {31'd0, res_valid}, 32'd0);
      chk("t4_gap_ready", {28'd0, req_ready}, 32'h4);
      step;
      set_req(2, 1'b1, 8'hFF, 8'h00, 1'b0);
      step;
      chk_res("t4_b2", 8'h00, 1'b1, 2'd2, 1'b0, 1'b0);
      set_req(2, 1'b1, 8'h00, 8'h00, 1'b1);
      step;
      chk_res("t4_b3", 8'h01, 1'b0, 2'd2, 1'b1, 1'b0);
      req_valid[2] = 1'b0;
      step;
      chk_res("t4_req3", 8'h02, 1'b0, 2'd3, 1'b1, 1'b0);
      req_valid = 4'h0;
      step;

      // backpressure
      do_reset;
      res_ready = 1'b0;
      set_req(0, 1'b1, 8'h2A, 8'h30, 1'b1);
      step;
      req_valid[0] = 1'b0;
      set_req(1, 1'b1, 8'h01, 8'h02, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_res("t5_hold", 8'h5A, 1'b0, 2'd0, 1'b1, 1'b0);
         chk("t5_stall_ready", {28'd0, req_ready}, 32'd0);
         step;
      end
      res_ready = 1'b1;
      #1 chk("t5_release_ready", {28'd0, req_ready}, 32'h2);
      step;
      chk_res("t5_b2b", 8'h03, 1'b0, 2'd1, 1'b1, 1'b0);
      req_valid = 4'h0;
      step;
      chk("t5_drain", {31'd0, res_valid}, 32'd0);

      // truncation at MAXBEATS
      do_reset;
      for (int k = 0; k < 5; k++) begin
         set_req(0, 1'b1, 8'hFF, 8'h01, (k == 4));
         step;
         chk_res("t6_beat", t6_sum[k], 1'b1, 2'd0, t6_last[k], t6_err[k]);
      end
      req_valid = 4'h0;
      step;

      // reset mid-transaction
      do_reset;
      set_req(1, 1'b1, 8'h11, 8'h22, 1'b0);
      step;
      set_req(1, 1'b1, 8'h33, 8'h44, 1'b0);
      rst = 1'b1;
      step;
      chk("t7_reset_valid", {31'd0, res_valid}, 32'd0);
      rst = 1'b0;
      set_req(0, 1'b1, 8'h05, 8'h06, 1'b1);
      set_req(1, 1'b1, 8'h07, 8'h08, 1'b1);
      step;
      chk_res("t7_rrptr", 8'h0B, 1'b0, 2'd0, 1'b1, 1'b0);
      req_valid = 4'h0;
      step;

      // random traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         req_valid = 4'($urandom_range(0, 15));
         for (int r = 0; r < NREQ; r++) begin
            req_a[r*8 +: 8] = 8'($urandom_range(0, 255));
            req_b[r*8 +: 8] = 8'($urandom_range(0, 255));
            req_last[r]     = ($urandom_range(0, 3) == 0);
         end
         res_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 299) == 0);
         step;
      end
      rst = 1'b0;
      req_valid = 4'h0;
      res_ready = 1'b1;
      step;
      step;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
